bp_cfg_link_regfile: RTL and testbench

BP_CFG_LINK_REGFILE -- requirements
Module: bp_cfg_link_regfile

---
 rtl/bp_cfg_link_regfile.sv | 241 ++++++++++++++++++++++++
 tb/tb_bp_cfg_link_regfile.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_link_regfile.sv
// Config-link register file: core control registers plus a CCE ucode bridge.
// Define BP_CFG_LINK_READBACK_EN to enable register and ucode readback.
module bp_cfg_link_regfile #(
    parameter int vaddr_width_p   = 39,
    parameter int num_lce_width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       cfg_v_i,
    input  logic                       cfg_w_i,
    input  logic [15:0]                cfg_addr_i,
    input  logic [31:0]                cfg_data_i,
    output logic                       cfg_ready_o,

    output logic                       cfg_v_o,
    output logic [31:0]                cfg_data_o,
    input  logic                       cfg_yumi_i,

    output logic [7:0]                 clk_osc_o,
    output logic                       core_reset_o,
    output logic                       freeze_o,
    output logic [1:0]                 icache_mode_o,
    output logic [1:0]                 dcache_mode_o,
    output logic [1:0]                 cce_mode_o,
    output logic [num_lce_width_p-1:0] num_lce_o,
    output logic [vaddr_width_p-1:0]   start_pc_o,

    output logic                       ucode_v_o,
    output logic                       ucode_w_o,
    output logic [11:0]                ucode_addr_o,
    output logic [31:0]                ucode_data_o,
    input  logic                       ucode_ready_i,
    input  logic                       ucode_v_i,
    input  logic [31:0]                ucode_data_i
);

    localparam int hi_w_lp = vaddr_width_p - 32;

    localparam logic [15:0] addr_clk_osc_lp  = 16'h0000;
    localparam logic [15:0] addr_reset_lp    = 16'h0001;
    localparam logic [15:0] addr_freeze_lp   = 16'h0002;
    localparam logic [15:0] addr_icache_lp   = 16'h0022;
    localparam logic [15:0] addr_pc_lo_lp    = 16'h0040;
    localparam logic [15:0] addr_pc_hi_lp    = 16'h0041;
    localparam logic [15:0] addr_dcache_lp   = 16'h0042;
    localparam logic [15:0] addr_cce_mode_lp = 16'h0060;
    localparam logic [15:0] addr_num_lce_lp  = 16'h0061;

`ifdef BP_CFG_LINK_READBACK_EN
    typedef enum logic [1:0] {
        IDLE,
        UCODE_REQ,
        UCODE_WAIT,
        RESP
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE,
        UCODE_REQ,
        RESP
    } state_e;
`endif

    state_e state_r, state_n;

    logic [7:0]                 clk_osc_r;
    logic                       core_reset_r;
    logic                       freeze_r;
    logic [1:0]                 icache_mode_r;
    logic [1:0]                 dcache_mode_r;
    logic [1:0]                 cce_mode_r;
    logic [num_lce_width_p-1:0] num_lce_r;
    logic [vaddr_width_p-1:0]   start_pc_r;

    logic                       ucode_w_r;
    logic [11:0]                ucode_addr_r;
    logic [31:0]                ucode_data_r;

    logic idle;
    logic accept;
    logic is_ucode;
    logic wr_reg;
    logic uc_issue;

    assign idle     = (state_r == IDLE);
    assign accept   = cfg_v_i & idle;
    assign is_ucode = (cfg_addr_i[15:12] == 4'h8);
    assign wr_reg   = accept & cfg_w_i & ~is_ucode;

`ifdef BP_CFG_LINK_READBACK_EN
    assign uc_issue = accept & is_ucode;
`else
    // Without readback only ucode writes ever reach the ucode port.
    assign uc_issue = accept & is_ucode & cfg_w_i;
`endif

    always_comb begin
        state_n     = state_r;
        cfg_ready_o = 1'b0;
        cfg_v_o     = 1'b0;
        ucode_v_o   = 1'b0;
        unique case (state_r)
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (uc_issue)
                    state_n = UCODE_REQ;
                else if (cfg_v_i & ~cfg_w_i)
                    state_n = RESP;
            end
            UCODE_REQ: begin
                ucode_v_o = 1'b1;
`ifdef BP_CFG_LINK_READBACK_EN
                if (ucode_ready_i)
                    state_n = ucode_w_r ? IDLE : UCODE_WAIT;
`else
                if (ucode_ready_i)
                    state_n = IDLE;
`endif
            end
`ifdef BP_CFG_LINK_READBACK_EN
            UCODE_WAIT: begin
                if (ucode_v_i)
                    state_n = RESP;
            end
`endif
            RESP: begin
                cfg_v_o = 1'b1;
                if (cfg_yumi_i)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_r <= IDLE;
        else
            state_r <= state_n;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_osc_r     <= '0;
            core_reset_r  <= 1'b1;
            freeze_r      <= 1'b1;
            icache_mode_r <= '0;
            dcache_mode_r <= '0;
            cce_mode_r    <= '0;
            num_lce_r     <= '0;
            start_pc_r    <= '0;
        end else if (wr_reg) begin
            unique case (1'b1)
                (cfg_addr_i == addr_clk_osc_lp):
                    clk_osc_r <= cfg_data_i[7:0];
                (cfg_addr_i == addr_reset_lp):
                    core_reset_r <= cfg_data_i[0];
                (cfg_addr_i == addr_freeze_lp):
                    freeze_r <= cfg_data_i[0];
                (cfg_addr_i == addr_icache_lp):
                    icache_mode_r <= cfg_data_i[1:0];
                (cfg_addr_i == addr_pc_lo_lp):
                    start_pc_r[31:0] <= cfg_data_i;
                (cfg_addr_i == addr_pc_hi_lp):
                    start_pc_r[vaddr_width_p-1:32] <= cfg_data_i[hi_w_lp-1:0];
                (cfg_addr_i == addr_dcache_lp):
                    dcache_mode_r <= cfg_data_i[1:0];
                (cfg_addr_i == addr_cce_mode_lp):
                    cce_mode_r <= cfg_data_i[1:0];
                (cfg_addr_i == addr_num_lce_lp):
                    num_lce_r <= cfg_data_i[num_lce_width_p-1:0];
                default: ;
            endcase
        end
    end

    // Request is captured once so the ucode port sees it stable while stalled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ucode_w_r    <= 1'b0;
            ucode_addr_r <= '0;
            ucode_data_r <= '0;
        end else if (uc_issue) begin
            ucode_w_r    <= cfg_w_i;
            ucode_addr_r <= cfg_addr_i[11:0];
            ucode_data_r <= cfg_data_i;
        end
    end

`ifdef BP_CFG_LINK_READBACK_EN
    logic [31:0] rd_data;
    logic [31:0] resp_data_r;

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            (cfg_addr_i == addr_clk_osc_lp):  rd_data = 32'(clk_osc_r);
            (cfg_addr_i == addr_reset_lp):    rd_data = 32'(core_reset_r);
            (cfg_addr_i == addr_freeze_lp):   rd_data = 32'(freeze_r);
            (cfg_addr_i == addr_icache_lp):   rd_data = 32'(icache_mode_r);
            (cfg_addr_i == addr_pc_lo_lp):    rd_data = start_pc_r[31:0];
            (cfg_addr_i == addr_pc_hi_lp):
                rd_data = 32'(start_pc_r[vaddr_width_p-1:32]);
            (cfg_addr_i == addr_dcache_lp):   rd_data = 32'(dcache_mode_r);
            (cfg_addr_i == addr_cce_mode_lp): rd_data = 32'(cce_mode_r);
            (cfg_addr_i == addr_num_lce_lp):  rd_data = 32'(num_lce_r);
            default:                          rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            resp_data_r <= '0;
        else if (accept & ~cfg_w_i & ~is_ucode)
            resp_data_r <= rd_data;
        else if ((state_r == UCODE_WAIT) & ucode_v_i)
            resp_data_r <= ucode_data_i;
    end

    assign cfg_data_o = resp_data_r;
`else
    logic unused_ucode_rsp;
    assign unused_ucode_rsp = ^{ucode_v_i, ucode_data_i};
    assign cfg_data_o       = '0;
`endif

    assign clk_osc_o     = clk_osc_r;
    assign core_reset_o  = core_reset_r;
    assign freeze_o      = freeze_r;
    assign icache_mode_o = icache_mode_r;
    assign dcache_mode_o = dcache_mode_r;
    assign cce_mode_o    = cce_mode_r;
    assign num_lce_o     = num_lce_r;
    assign start_pc_o    = start_pc_r;

    assign ucode_w_o    = ucode_w_r;
    assign ucode_addr_o = ucode_addr_r;
    assign ucode_data_o = ucode_data_r;

endmodule

// File: tb/tb_bp_cfg_link_regfile.sv
// Directed bench for bp_cfg_link_regfile with a transaction-level model.
// Expectations follow BP_CFG_LINK_READBACK_EN when the macro is defined.
module tb_bp_cfg_link_regfile;

    localparam int VW = 39;
    localparam int NL = 8;
    localparam logic [63:0] HI_MASK = (64'd1 << (VW - 32)) - 64'd1;
`ifdef BP_CFG_LINK_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          cfg_v_i = 1'b0;
    logic          cfg_w_i = 1'b0;
    logic [15:0]   cfg_addr_i = '0;
    logic [31:0]   cfg_data_i = '0;
    logic          cfg_ready_o;
    logic          cfg_v_o;
    logic [31:0]   cfg_data_o;
    logic          cfg_yumi_i = 1'b0;
    logic [7:0]    clk_osc_o;
    logic          core_reset_o;
    logic          freeze_o;
    logic [1:0]    icache_mode_o;
    logic [1:0]    dcache_mode_o;
    logic [1:0]    cce_mode_o;
    logic [NL-1:0] num_lce_o;
    logic [VW-1:0] start_pc_o;
    logic          ucode_v_o;
    logic          ucode_w_o;
    logic [11:0]   ucode_addr_o;
    logic [31:0]   ucode_data_o;
    logic          ucode_ready_i = 1'b0;
    logic          ucode_v_i = 1'b0;
    logic [31:0]   ucode_data_i = '0;

    bp_cfg_link_regfile #(
        .vaddr_width_p  (VW),
        .num_lce_width_p(NL)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .cfg_v_i      (cfg_v_i),
        .cfg_w_i      (cfg_w_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_v_o      (cfg_v_o),
        .cfg_data_o   (cfg_data_o),
        .cfg_yumi_i   (cfg_yumi_i),
        .clk_osc_o    (clk_osc_o),
        .core_reset_o (core_reset_o),
        .freeze_o     (freeze_o),
        .icache_mode_o(icache_mode_o),
        .dcache_mode_o(dcache_mode_o),
        .cce_mode_o   (cce_mode_o),
        .num_lce_o    (num_lce_o),
        .start_pc_o   (start_pc_o),
        .ucode_v_o    (ucode_v_o),
        .ucode_w_o    (ucode_w_o),
        .ucode_addr_o (ucode_addr_o),
        .ucode_data_o (ucode_data_o),
        .ucode_ready_i(ucode_ready_i),
        .ucode_v_i    (ucode_v_i),
        .ucode_data_i (ucode_data_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int u_hs = 0;

    // Model of the architectural register contents.
    logic [7:0]    m_osc;
    logic          m_core_reset;
    logic          m_freeze;
    logic [1:0]    m_ic;
    logic [1:0]    m_dc;
    logic [1:0]    m_cce;
    logic [NL-1:0] m_lce;
    logic [63:0]   m_pc;

    // Expected handshake-visible behaviour.
    logic          exp_ready;
    logic          exp_cv;
    logic [31:0]   exp_cdata;
    logic          exp_uv;
    logic          exp_uw;
    logic [11:0]   exp_uaddr;
    logic [31:0]   exp_udata;

    function automatic void check(input string nm, input logic [63:0] got,
                                  input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        m_osc = '0;
        m_core_reset = 1'b1;
        m_freeze = 1'b1;
        m_ic = '0;
        m_dc = '0;
        m_cce = '0;
        m_lce = '0;
        m_pc = '0;
        exp_ready = 1'b1;
        exp_cv = 1'b0;
        exp_cdata = '0;
        exp_uv = 1'b0;
        exp_uw = 1'b0;
        exp_uaddr = '0;
        exp_udata = '0;
    endfunction

    function automatic void m_write(input logic [15:0] a, input logic [31:0] d);
        case (a)
            16'h0000: m_osc = d[7:0];
            16'h0001: m_core_reset = d[0];
            16'h0002: m_freeze = d[0];
            16'h0022: m_ic = d[1:0];
            16'h0040: m_pc = (m_pc & ~64'hFFFF_FFFF) | 64'(d);
            16'h0041: m_pc = (m_pc & 64'hFFFF_FFFF) | ((64'(d) & HI_MASK) << 32);
            16'h0042: m_dc = d[1:0];
            16'h0060: m_cce = d[1:0];
            16'h0061: m_lce = d[NL-1:0];
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            16'h0000: r = 32'(m_osc);
            16'h0001: r = 32'(m_core_reset);
            16'h0002: r = 32'(m_freeze);
            16'h0022: r = 32'(m_ic);
            16'h0040: r = m_pc[31:0];
            16'h0041: r = m_pc[63:32];
            16'h0042: r = 32'(m_dc);
            16'h0060: r = 32'(m_cce);
            16'h0061: r = 32'(m_lce);
            default:  r = '0;
        endcase
        return RB ? r : 32'h0;
    endfunction

    always @(posedge clk)
        if (chk_en && ucode_v_o && ucode_ready_i)
            u_hs++;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cfg_ready", 64'(cfg_ready_o), 64'(exp_ready));
            check("cfg_v", 64'(cfg_v_o), 64'(exp_cv));
            if (exp_cv)
                check("cfg_data", 64'(cfg_data_o), 64'(exp_cdata));
            check("ucode_v", 64'(ucode_v_o), 64'(exp_uv));
            if (exp_uv) begin
                check("ucode_w", 64'(ucode_w_o), 64'(exp_uw));
                check("ucode_addr", 64'(ucode_addr_o), 64'(exp_uaddr));
                check("ucode_data", 64'(ucode_data_o), 64'(exp_udata));
            end
            check("clk_osc", 64'(clk_osc_o), 64'(m_osc));
            check("core_reset", 64'(core_reset_o), 64'(m_core_reset));
            check("freeze", 64'(freeze_o), 64'(m_freeze));
            check("icache_mode", 64'(icache_mode_o), 64'(m_ic));
            check("dcache_mode", 64'(dcache_mode_o), 64'(m_dc));
            check("cce_mode", 64'(cce_mode_o), 64'(m_cce));
            check("num_lce", 64'(num_lce_o), 64'(m_lce));
            check("start_pc", 64'(start_pc_o), m_pc & ((64'd1 << VW) - 64'd1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [31:0] d);
        cfg_v_i = 1'b1;
        cfg_w_i = 1'b1;
        cfg_addr_i = a;
        cfg_data_i = d;
        tick();
        cfg_v_i = 1'b0;
        cfg_data_i = 32'h5A5A_5A5A;
        m_write(a, d);
    endtask

    task automatic reg_read(input logic [15:0] a, input int yd,
                            input logic [31:0] lit, input bit intr);
        cfg_v_i = 1'b1;
        cfg_w_i = 1'b0;
        cfg_addr_i = a;
        tick();
        cfg_v_i = 1'b0;
        exp_ready = 1'b0;
        exp_cv = 1'b1;
        exp_cdata = m_read(a);
        check("rd_lit", 64'(cfg_data_o), 64'(RB ? lit : 32'h0));
        if (intr) begin
            cfg_v_i = 1'b1;
            cfg_w_i = 1'b1;
            cfg_addr_i = 16'h0000;
            cfg_data_i = 32'h0000_00FF;
        end
        repeat (yd) tick();
        cfg_v_i = 1'b0;
        cfg_yumi_i = 1'b1;
        tick();
        cfg_yumi_i = 1'b0;
        exp_cv = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic ucode_write(input logic [15:0] a, input logic [31:0] d,
                               input int rd);
        cfg_v_i = 1'b1;
        cfg_w_i = 1'b1;
        cfg_addr_i = a;
        cfg_data_i = d;
        tick();
        cfg_v_i = 1'b0;
        cfg_addr_i = 16'h0000;
        cfg_data_i = ~d;
        exp_ready = 1'b0;
        exp_uv = 1'b1;
        exp_uw = 1'b1;
        exp_uaddr = a[11:0];
        exp_udata = d;
        repeat (rd) tick();
        ucode_ready_i = 1'b1;
        tick();
        ucode_ready_i = 1'b0;
        exp_uv = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic ucode_read(input logic [15:0] a, input logic [31:0] d,
                              input int rd, input int wd, input int yd);
        cfg_v_i = 1'b1;
        cfg_w_i = 1'b0;
        cfg_addr_i = a;
        cfg_data_i = 32'h0BAD_F00D;
        tick();
        cfg_v_i = 1'b0;
        cfg_data_i = 32'h0;
        exp_ready = 1'b0;
        if (RB) begin
            exp_uv = 1'b1;
            exp_uw = 1'b0;
            exp_uaddr = a[11:0];
            exp_udata = 32'h0BAD_F00D;
            repeat (rd) tick();
            ucode_ready_i = 1'b1;
            tick();
            ucode_ready_i = 1'b0;
            exp_uv = 1'b0;
            repeat (wd) tick();
            ucode_v_i = 1'b1;
            ucode_data_i = d;
            tick();
            ucode_v_i = 1'b0;
            ucode_data_i = 32'h0;
            exp_cv = 1'b1;
            exp_cdata = d;
        end else begin
            exp_cv = 1'b1;
            exp_cdata = 32'h0;
        end
        check("ucode_rsp_lit", 64'(cfg_data_o), 64'(RB ? d : 32'h0));
        repeat (yd) tick();
        cfg_yumi_i = 1'b1;
        tick();
        cfg_yumi_i = 1'b0;
        exp_cv = 1'b0;
        exp_ready = 1'b1;
    endtask

    initial begin
        int hs0;
        m_reset();
        reset_i = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset_i = 1'b0;
        tick();
        check("rst_freeze", 64'(freeze_o), 64'd1);
        check("rst_core_reset", 64'(core_reset_o), 64'd1);
        check("rst_start_pc", 64'(start_pc_o), 64'd0);
        check("rst_cfg_v", 64'(cfg_v_o), 64'd0);
        check("rst_ucode_v", 64'(ucode_v_o), 64'd0);

        reg_write(16'h0002, 32'h0);
        check("unfreeze", 64'(freeze_o), 64'd0);
        check("core_reset_held", 64'(core_reset_o), 64'd1);

        reg_write(16'h0000, 32'h0000_01A5);
        check("clk_osc_trunc", 64'(clk_osc_o), 64'hA5);
        reg_write(16'h0022, 32'h7);
        reg_write(16'h0042, 32'h2);
        reg_write(16'h0060, 32'h1);
        reg_write(16'h0061, 32'h1234);
        check("num_lce_trunc", 64'(num_lce_o), 64'h34);

        reg_write(16'h0040, 32'h8000_0000);
        reg_write(16'h0041, 32'h0000_0012);
        check("start_pc_lit", 64'(start_pc_o), 64'h12_8000_0000);
        reg_read(16'h0041, 0, 32'h12, 1'b0);
        reg_read(16'h0040, 2, 32'h8000_0000, 1'b0);
        reg_read(16'h0022, 1, 32'h3, 1'b0);
        reg_read(16'h0061, 0, 32'h34, 1'b0);
        reg_read(16'h0001, 0, 32'h1, 1'b0);
        reg_write(16'h0041, 32'hFFFF_FFFF);
        check("start_pc_hi_trunc", 64'(start_pc_o), 64'h7F_8000_0000);
        reg_read(16'h0041, 0, 32'h7F, 1'b0);

        reg_read(16'h0050, 1, 32'h0, 1'b0);
        reg_write(16'h0050, 32'hFFFF_FFFF);
        reg_read(16'h9000, 0, 32'h0, 1'b0);
        reg_write(16'h9000, 32'hFFFF_FFFF);
        reg_write(16'h0003, 32'h1);

        ucode_v_i = 1'b1;
        ucode_data_i = 32'h0000_0BAD;
        tick();
        ucode_v_i = 1'b0;
        ucode_data_i = 32'h0;

        hs0 = u_hs;
        ucode_write(16'h8123, 32'hDEAD_BEEF, 3);
        check("ucode_one_accept", 64'(u_hs - hs0), 64'd1);
        ucode_write(16'h8FFF, 32'h0000_0001, 0);
        hs0 = u_hs;
        ucode_read(16'h8005, 32'h1234_5678, 0, 0, 4);
        ucode_read(16'h8ABC, 32'h0F0F_A5A5, 1, 2, 0);
        check("ucode_rd_accepts", 64'(u_hs - hs0), RB ? 64'd2 : 64'd0);

        reg_read(16'h0002, 3, 32'h0, 1'b1);
        check("busy_write_dropped", 64'(clk_osc_o), 64'hA5);

        cfg_v_i = 1'b1;
        cfg_w_i = RB ? 1'b0 : 1'b1;
        cfg_addr_i = RB ? 16'h8007 : 16'h8010;
        cfg_data_i = 32'h0000_5555;
        tick();
        cfg_v_i = 1'b0;
        exp_ready = 1'b0;
        exp_uv = 1'b1;
        exp_uw = !RB;
        exp_uaddr = RB ? 12'h007 : 12'h010;
        exp_udata = 32'h0000_5555;
        if (RB) begin
            ucode_ready_i = 1'b1;
            tick();
            ucode_ready_i = 1'b0;
            exp_uv = 1'b0;
        end
        tick();
        reset_i = 1'b1;
        tick();
        m_reset();
        reset_i = 1'b0;
        check("mid_rst_ucode_v", 64'(ucode_v_o), 64'd0);
        check("mid_rst_cfg_v", 64'(cfg_v_o), 64'd0);
        check("mid_rst_ready", 64'(cfg_ready_o), 64'd1);
        tick();
        ucode_v_i = 1'b1;
        ucode_data_i = 32'hCAFE_F00D;
        tick();
        ucode_v_i = 1'b0;
        ucode_data_i = 32'h0;
        check("late_ucode_v_ignored", 64'(cfg_v_o), 64'd0);
        tick();

        reg_write(16'h0060, 32'h3);
        reg_read(16'h0060, 0, 32'h3, 1'b0);
        reg_read(16'h0002, 0, 32'h1, 1'b0);
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
